// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline header for the data-memory access unit: FSM state encodings
// and the default timeout constant.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mau_state_e;

  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/mem_access_unit_timeout_cnt.sv
// Request-cycle counter for the memory access unit; flags the last allowed
// REQ cycle. Instantiated by the top only when MEM_TIMEOUT_EN is defined.
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Raised during the TIMEOUT_CYC-th REQ cycle so the FSM leaves on that edge.
  assign o_expired = i_en && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: IDLE/REQ/DONE handshake with pipeline stall.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int INST_SZ     = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [INST_SZ-1:0] i_addr,
  input  logic [INST_SZ-1:0] i_write_data,
  input  logic               i_mem_ack,
  input  logic [INST_SZ-1:0] i_mem_rdata,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [INST_SZ-1:0] o_mem_addr,
  output logic [INST_SZ-1:0] o_mem_wdata,
  output logic [INST_SZ-1:0] o_read_data,
  output logic               o_stall,
  output logic               o_error
);

  mau_state_e         state_q, state_d;
  logic               is_wr_q, is_wr_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [INST_SZ-1:0] addr_q, addr_d;
  logic [INST_SZ-1:0] wdata_q, wdata_d;
  logic [INST_SZ-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               cnt_clr;
  logic               tmo_hit;
  logic               stall;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (cnt_clr),
    .i_en      (state_q == ST_REQ),
    .o_expired (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_mem_read || i_mem_write) begin
          stall   = 1'b1;
          state_d = ST_REQ;
          addr_d  = i_addr;
          wdata_d = i_write_data;
          is_wr_d = i_mem_write;  // write wins when both controls are high
          cnt_clr = 1'b1;
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (i_mem_ack) begin
          state_d = ST_DONE;
          if (!is_wr_q) rdata_d = i_mem_rdata;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (!is_wr_q) rdata_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Registered strobes follow the next state so they are high exactly in REQ.
    req_d = (state_d == ST_REQ);
    we_d  = (state_d == ST_REQ) && is_wr_d;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      is_wr_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_read_data = rdata_q;
  assign o_stall     = stall;
  assign o_error     = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (both MEM_TIMEOUT_EN builds).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, ack;
  logic [31:0] addr, wdata, rdata;
  logic        mem_req, mem_we, stall, error;
  logic [31:0] mem_addr, mem_wdata, read_data;

  int n_checks = 0;
  int n_pass   = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .INST_SZ     (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_mem_read   (rd),
    .i_mem_write  (wr),
    .i_addr       (addr),
    .i_write_data (wdata),
    .i_mem_ack    (ack),
    .i_mem_rdata  (rdata),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_read_data  (read_data),
    .o_stall      (stall),
    .o_error      (error)
  );

  always @(negedge clk) begin
    if (mem_req && !req_prev) req_rises++;
    req_prev = mem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int rises0;
    int reqc;
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; ack = 1'b0;
    addr = '0; wdata = '0; rdata = '0;

    // Reset state
    step();
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_err", error, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;

    // Load from 0x40, ack in the second REQ cycle
    step();
    rd = 1'b1; addr = 32'h40; #1;
    chk("ld_stall_idle", stall, 1);
    chk("ld_req_idle", mem_req, 0);
    step();
    chk("ld_req", mem_req, 1);
    chk("ld_we", mem_we, 0);
    chk("ld_addr", mem_addr, 32'h40);
    chk("ld_stall_req1", stall, 1);
    addr = 32'hFFFF_0000;  // must not disturb the latched address
    step();
    chk("ld_addr_hold", mem_addr, 32'h40);
    chk("ld_stall_req2", stall, 1);
    ack = 1'b1; rdata = 32'hDEADBEEF;
    step();
    ack = 1'b0; rdata = 32'h0BAD_0BAD; #1;
    chk("ld_rdata", read_data, 32'hDEADBEEF);
    chk("ld_stall_done", stall, 0);
    chk("ld_req_done", mem_req, 0);
    rd = 1'b0;

    // Store to 0x10, immediate ack
    step();
    wr = 1'b1; addr = 32'h10; wdata = 32'h12345678;
    step();
    chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 32'h10);
    chk("st_wdata", mem_wdata, 32'h12345678);
    ack = 1'b1;
    step();
    ack = 1'b0; #1;
    chk("st_rdata_kept", read_data, 32'hDEADBEEF);
    chk("st_stall_done", stall, 0);
    wr = 1'b0;

    // Both controls high: a single write request
    step();
    rises0 = req_rises;
    rd = 1'b1; wr = 1'b1; addr = 32'h20;
    step();
    chk("both_we", mem_we, 1);
    chk("both_addr", mem_addr, 32'h20);
    ack = 1'b1;
    step();
    ack = 1'b0; rd = 1'b0; wr = 1'b0;
    step();
    step();
    chk("both_req_idle", mem_req, 0);
    chk("both_one_req", 32'(req_rises - rises0), 1);

    // Reset asserted while in REQ
    rd = 1'b1; addr = 32'h80;
    step();
    chk("rr_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_req_async", mem_req, 0);
    chk("rr_addr_async", mem_addr, 0);
    chk("rr_rdata_async", read_data, 0);
    step();
    rst_n = 1'b1; rd = 1'b0;
    step();
    ack = 1'b1; rdata = 32'hCAFEF00D;
    step();
    ack = 1'b0; #1;
    chk("rr_late_ack_req", mem_req, 0);
    chk("rr_late_ack_stall", stall, 0);
    chk("rr_late_ack_rdata", read_data, 0);

    // Ack in IDLE with no access is ignored
    ack = 1'b1;
    step();
    ack = 1'b0; #1;
    chk("idle_ack_req", mem_req, 0);

    // Back-to-back loads from 0x0 and 0x4
    rises0 = req_rises;
    rd = 1'b1; addr = 32'h0; rdata = 32'h11111111;
    step();
    chk("b2b_req0", mem_req, 1);
    chk("b2b_addr0", mem_addr, 32'h0);
    ack = 1'b1;
    step();
    chk("b2b_rdata0", read_data, 32'h11111111);
    chk("b2b_req_done", mem_req, 0);
    addr = 32'h4; rdata = 32'h22222222;  // ack still high across DONE
    step();
    ack = 1'b0; #1;
    chk("b2b_req_idle", mem_req, 0);
    chk("b2b_stall_idle", stall, 1);
    step();
    chk("b2b_req1", mem_req, 1);
    chk("b2b_addr1", mem_addr, 32'h4);
    step();
    chk("b2b_req1_wait", mem_req, 1);
    ack = 1'b1;
    step();
    ack = 1'b0; rd = 1'b0; #1;
    chk("b2b_rdata1", read_data, 32'h22222222);
    chk("b2b_two_reqs", 32'(req_rises - rises0), 2);

    // Load that is never acknowledged
    step();
    rd = 1'b1; addr = 32'h100;
`ifdef MEM_TIMEOUT_EN
    reqc = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_req) reqc++;
      chk("to_err_low", error, 0);
    end
    chk("to_req_cycles", 32'(reqc), 4);
    step();
    chk("to_req_done", mem_req, 0);
    chk("to_err_pulse", error, 1);
    chk("to_rdata_zero", read_data, 0);
    chk("to_stall_done", stall, 0);
    rd = 1'b0;
    step();
    chk("to_err_cleared", error, 0);
`else
    reqc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req && !error) reqc++;
    end
    chk("wait_req_held", 32'(reqc), 20);
    chk("wait_rdata_kept", read_data, 32'h22222222);
    rdata = 32'h33333333; ack = 1'b1;
    step();
    ack = 1'b0; rd = 1'b0; #1;
    chk("wait_rdata", read_data, 32'h33333333);
    chk("wait_err", error, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter INST_SZ, default 32, SHALL set the address and data width.
REQ-002 Parameter TIMEOUT_CYC, default 16, SHALL set the number of REQ cycles without acknowledge before a timeout. It is used only when MEM_TIMEOUT_EN is defined.
REQ-003 i_clk  in  1  single clock; all state changes on the rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_mem_read  in  1  MemRead control, driven from the EX/MEM register output.
REQ-006 i_mem_write  in  1  MemWrite control, driven from the EX/MEM register output.
REQ-007 i_addr  in  INST_SZ  access address; carries the ALU result.
REQ-008 i_write_data  in  INST_SZ  store data.
REQ-009 i_mem_ack  in  1  data-memory acknowledge.
REQ-010 i_mem_rdata  in  INST_SZ  data-memory read data; valid when i_mem_ack is high.
REQ-011 o_mem_req  out  1  memory request; registered.
REQ-012 o_mem_we  out  1  write strobe qualifying o_mem_req; registered.
REQ-013 o_mem_addr, o_mem_wdata  out  INST_SZ each  latched access address and store data.
REQ-014 o_read_data  out  INST_SZ  captured load data.
REQ-015 o_stall  out  1  pipeline freeze; drives the EX/MEM and upstream register enables low.
REQ-016 o_error  out  1  one-cycle timeout pulse.

Function
REQ-017 The block SHALL implement an FSM with three states:
- IDLE: no access in flight.
- REQ: request outstanding.
- DONE: access complete; pipeline released.
REQ-018 IDLE transitions:
- If i_mem_read or i_mem_write is high, the block SHALL latch i_addr, i_write_data and access type, and go to REQ.
- Otherwise it SHALL stay in IDLE.
REQ-019 If i_mem_read and i_mem_write are both high, the access SHALL be a write.
REQ-020 REQ behaviour:
- o_mem_req SHALL be 1.
- o_mem_we SHALL be 1 for a write and 0 for a read.
- Address and write data SHALL be held stable until acknowledge.
REQ-021 In REQ with i_mem_ack=1, the block SHALL go to DONE. For a read, it SHALL capture i_mem_rdata into o_read_data on that edge.
REQ-022 From DONE the block SHALL return to IDLE unconditionally after one cycle.
REQ-023 o_stall SHALL be combinational:
- 1 in REQ.
- 1 in IDLE while an access is requested.
- 0 otherwise, including DONE.
As a result, EX/MEM advances exactly at the end of DONE.
REQ-024 Latency:
- Access sampled in cycle T gives o_mem_req high from T+1.
- The earliest acknowledge is at T+1.
- The minimum access time is 3 cycles: T to DONE inclusive.
REQ-025 The block SHALL ignore i_mem_ack in IDLE and DONE.
REQ-026 o_read_data SHALL hold its value between loads; writes SHALL NOT alter it.
REQ-027 The block SHALL NOT re-issue an access while the same instruction is held. Only DONE→IDLE permits a new access.

Reset
REQ-028 Assertion of i_reset SHALL immediately force:
- state to IDLE;
- o_mem_req and o_mem_we to 0;
- o_mem_addr, o_mem_wdata and o_read_data to 0;
- o_error to 0;
- the timeout counter to 0.
REQ-029 Reset in REQ SHALL abandon the access; a late i_mem_ack after deassertion SHALL be ignored.
REQ-030 Reset deassertion SHALL be synchronised to i_clk by the top level. The block SHALL leave IDLE no earlier than the first edge after deassertion.

Configuration
REQ-031 With MEM_TIMEOUT_EN defined:
- A counter SHALL count REQ cycles.
- When the count reaches TIMEOUT_CYC with no acknowledge, the block SHALL go to DONE and pulse o_error for the DONE cycle.
- The counter SHALL clear on entry to REQ.
REQ-032 On a timed-out load, o_read_data SHALL be set to 0.
REQ-033 Without MEM_TIMEOUT_EN:
- REQ SHALL wait indefinitely.
- o_error SHALL be tied to 0.
- The counter and TIMEOUT_CYC SHALL have no hardware.

Structure
REQ-034 The shared pipeline header SHALL hold the FSM state encodings (IDLE=2'b00, REQ=2'b01, DONE=2'b10) and the default TIMEOUT_CYC constant.
REQ-035 The timeout counter SHALL be a sub-module, mem_timeout_cnt, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-036 Load: i_mem_read=1, i_addr=0x40, acknowledge 2 cycles after the request with i_mem_rdata=0xDEADBEEF → o_read_data=0xDEADBEEF; o_stall high for 3 cycles.
REQ-037 Store: i_mem_write=1, i_addr=0x10, i_write_data=0x12345678, immediate acknowledge → o_mem_we=1, o_mem_wdata=0x12345678, o_read_data unchanged.
REQ-038 Both controls high, i_addr=0x20 → o_mem_we=1; a single request only.
REQ-039 Reset asserted in REQ → o_mem_req=0 without waiting for a clock edge; acknowledge one cycle after release is ignored; state stays IDLE.
REQ-040 With MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no acknowledge on a load → DONE after 4 REQ cycles, o_error one-cycle pulse, o_read_data=0.
REQ-041 Back-to-back loads from 0x0 and 0x4 → two distinct requests separated by one DONE cycle; i_mem_ack asserted in IDLE is ignored.
